// File: rtl/coprocessor_mem_reader.sv
// Custom-instruction slave that reads one word, or the wrapping sum of a run of
// words, from the coprocessor data memory through its pipelined read port.
module coprocessor_mem_reader #(
   parameter int ADDR_WIDTH = 10,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_en,
   input  logic                  start,
   input  logic [31:0]           dataa,
   input  logic [31:0]           datab,
   output logic [31:0]           result,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rdaddress,
   output logic                  rden,
   input  logic [31:0]           q
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [CW-1:0]           issue_cnt, recv_cnt, n_req;
   logic [31:0]             acc, result_q;
   logic [RD_LATENCY:1]     vld_pipe;
   logic                    accept, ret, last_ret;
   logic                    unused_bits;

   assign unused_bits = ^{dataa[31:ADDR_WIDTH], datab[31:CW]};

   // Count 0 means one word; anything past the memory depth reads it all once.
   always_comb begin
      n_req = datab[CW-1:0];
      if (n_req == '0)
         n_req = CW'(1);
      else if (n_req > DEPTH)
         n_req = DEPTH;
   end

   assign accept    = (state == IDLE) && clk_en && start;
   assign rden      = (state == ISSUE) && clk_en;
   assign rdaddress = addr;
   assign ret       = vld_pipe[RD_LATENCY];
   assign last_ret  = ret && (recv_cnt == CW'(1));
   assign done      = (state == FINISH) && clk_en;
   assign result    = done ? acc : result_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   if (clk_en && issue_cnt == CW'(1)) state_nxt = DRAIN;
         DRAIN:   if (last_ret) state_nxt = FINISH;
         FINISH:  if (clk_en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         addr      <= '0;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         acc       <= '0;
         result_q  <= '0;
         vld_pipe  <= '0;
      end else begin
         state <= state_nxt;
         // Return tracking runs regardless of clk_en so no in-flight word is lost.
         vld_pipe[1] <= rden;
         for (int i = 2; i <= RD_LATENCY; i++)
            vld_pipe[i] <= vld_pipe[i-1];
         if (accept) begin
            addr      <= dataa[ADDR_WIDTH-1:0];
            issue_cnt <= n_req;
            recv_cnt  <= n_req;
            acc       <= '0;
         end else begin
            if (rden) begin
               addr      <= addr + 1'b1;
               issue_cnt <= issue_cnt - 1'b1;
            end
            if (ret) begin
               acc      <= acc + q;
               recv_cnt <= recv_cnt - 1'b1;
            end
         end
         if (done)
            result_q <= acc;
      end
   end

endmodule
